// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, fetches words over imem req/ack into a QDEPTH-entry queue.
// Ack at N -> instr_valid at N+1; fetching pauses when the queue is full; a decoder redirect flushes the queue.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        branch,
  input  logic        aluZero
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic [31:0]   q_instr [QDEPTH];
  logic [31:0]   q_pc    [QDEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic          pop;
  logic          push;
  logic          redirect;
  logic [31:0]   pc_plus4;
  logic [31:0]   jump_tgt;
  logic [31:0]   br_tgt;
  logic [31:0]   target;
  logic [CW-1:0] count_pop;
  logic [CW-1:0] count_nxt;

  assign instr_valid = (count != '0);
  assign instr_out   = q_instr[head];
  assign instr_pc    = q_pc[head];
  assign imem_req    = (state != IDLE);
  assign imem_addr   = req_addr;

  assign pop       = instr_valid & instr_ready;
  assign pc_plus4  = instr_pc + 32'd4;
  assign jump_tgt  = {pc_plus4[31:28], instr_out[25:0], 2'b00};
  assign br_tgt    = pc_plus4 + {{14{instr_out[15]}}, instr_out[15:0], 2'b00};
  assign target    = jump ? jump_tgt : br_tgt;
  assign redirect  = pop & (jump | (branch & aluZero));
  // A word arriving in the same cycle as a redirect belongs to the abandoned path.
  assign push      = (state == WAIT) & imem_ack & ~redirect;
  assign count_pop = count - CW'(pop);
  assign count_nxt = count_pop + CW'(push);

  // req_addr tracks the outstanding request; fetch_pc may already hold a redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= target;
            req_addr <= target;
            state    <= WAIT;
          end else if (count_pop < QFULL) begin
            req_addr <= fetch_pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc <= target;
            if (imem_ack) begin
              req_addr <= target;
              state    <= WAIT;
            end else begin
              state    <= DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            req_addr <= fetch_pc + 32'd4;
            state    <= (count_nxt < QFULL) ? WAIT : IDLE;
          end
        end
        DROP: begin
          if (redirect) begin
            fetch_pc <= target;
          end
          if (imem_ack) begin
            req_addr <= redirect ? target : fetch_pc;
            state    <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_instr[tail] <= imem_rdata;
        q_pc[tail]    <= fetch_pc;
        tail          <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: latency-configurable memory responder, small decoder model,
// and scoreboards for issued fetch addresses and delivered {instr, pc} pairs.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        branch;
  logic        aluZero;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int cnt = 0;
  int ack_count = 0;
  int br_seen = 0;
  bit jmp_en = 1'b0;
  bit br_en = 1'b0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_addr_q[$];

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_out(instr_out),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jump(jump),
    .branch(branch),
    .aluZero(aluZero)
  );

  // Program image: opcode 0x28 filler words, plus a jump at 0x10 and a beq at 0x20 when enabled.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jmp_en && a == 32'h10) return 32'h0800_0040;
    if (br_en && a == 32'h20) return 32'h1000_FFFE;
    return 32'hA000_0000 ^ a;
  endfunction

  assign jump    = (instr_out[31:26] == 6'h02);
  assign branch  = (instr_out[31:26] == 6'h04);
  assign aluZero = (br_seen == 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) br_seen <= 0;
    else if (instr_valid && instr_ready && branch) br_seen <= br_seen + 1;
  end

  // Memory responder: acks after lat idle cycles of a held request.
  always @(negedge clk) begin
    if (!rst_n) ack_count = 0;
    if (imem_req) begin
      if (cnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        cnt        = 0;
        ack_count++;
        if (exp_addr_q.size() > 0) chk("imem_addr", imem_addr, exp_addr_q.pop_front());
      end else begin
        imem_ack = 1'b0;
        cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      cnt      = 0;
    end
  end

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst_n && instr_valid && instr_ready && exp_pc_q.size() > 0) begin
      e = exp_pc_q.pop_front();
      chk("instr_pc", instr_pc, e);
      chk("instr_out", instr_out, mem_word(e));
    end
  end

  task automatic add_pcs(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_pc_q.push_back(start + 32'(4 * i));
  endtask

  task automatic add_addrs(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(start + 32'(4 * i));
  endtask

  task automatic start_phase(input int l, input logic r, input bit je, input bit be);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    lat = l;
    instr_ready = r;
    jmp_en = je;
    br_en = be;
    exp_pc_q.delete();
    exp_addr_q.delete();
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    repeat (2) @(posedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && (exp_pc_q.size() > 0 || exp_addr_q.size() > 0); i++)
      @(posedge clk);
    chk({name, "_pc_left"}, 32'(exp_pc_q.size()), 32'd0);
    chk({name, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    instr_ready = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;

    // Sequential stream, ack every cycle, decode always ready.
    start_phase(0, 1'b1, 1'b0, 1'b0);
    add_pcs(32'h0, 8);
    add_addrs(32'h0, 8);
    release_rst();
    #1;
    chk("req_before_first_edge", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("valid_before_ack_edge", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("valid_after_ack", 32'(instr_valid), 32'd1);
    chk("first_instr_pc", instr_pc, 32'h0);
    wait_drain("seq");

    // Decode stalled: exactly two words fetched, then the request drops.
    start_phase(0, 1'b0, 1'b0, 1'b0);
    add_pcs(32'h0, 6);
    add_addrs(32'h0, 6);
    release_rst();
    repeat (10) @(posedge clk);
    #1;
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_acks", 32'(ack_count), 32'd2);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    wait_drain("stall");

    // Jump at 0x10 while 0x14 is outstanding: 0x14 acked then dropped, fetch resumes at 0x100.
    start_phase(2, 1'b1, 1'b1, 1'b0);
    add_pcs(32'h0, 5);
    add_pcs(32'h100, 3);
    add_addrs(32'h0, 6);
    add_addrs(32'h100, 3);
    release_rst();
    wait_drain("jump");

    // beq at 0x20 taken back to 0x1C (coincides with ack of 0x24), then not taken.
    start_phase(0, 1'b1, 1'b0, 1'b1);
    add_pcs(32'h0, 9);
    add_pcs(32'h1C, 5);
    add_addrs(32'h0, 10);
    add_addrs(32'h1C, 5);
    release_rst();
    wait_drain("branch");

    // Reset pulse while a request is outstanding and a word is queued.
    start_phase(2, 1'b0, 1'b0, 1'b0);
    add_addrs(32'h0, 1);
    release_rst();
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    add_pcs(32'h0, 3);
    add_addrs(32'h0, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    instr_ready = 1'b1;
    wait_drain("rst_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
